// File: rtl/stopwatch_2hz_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_2hz_ctrl
//
// Start/stop/clear stopwatch with 0.5 s resolution and a BCD MM:SS.h readout.
// The 2 Hz square wave from the upstream divider is treated as data: it is
// synchronised into the clk_50m domain and its rising edge becomes a one-cycle
// tick. No logic here is clocked by clk_2hz.
//
// Parameters
//   SYNC_STAGES   flops per input synchroniser (>= 2)
//   MAX_MIN_TENS  BCD tens digit of the last minute before wrap
//   MAX_MIN_ONES  BCD ones digit of the last minute before wrap
//
// Ports
//   clk_50m     in   system clock
//   rst_n       in   asynchronous active-low reset
//   clk_2hz     in   2 Hz square wave (asynchronous to clk_50m)
//   start_stop  in   debounced key level; a rising edge toggles run/pause
//   clear       in   debounced key level; clears everything while high
//   tick_out    out  one-cycle pulse per detected clk_2hz rising edge
//   half        out  0.5 s digit (0 = .0, 1 = .5)
//   sec_ones    out  BCD 0..9
//   sec_tens    out  BCD 0..5
//   min_ones    out  BCD 0..9
//   min_tens    out  BCD 0..MAX_MIN_TENS
//   running     out  high while in RUN
//   rollover    out  one-cycle pulse when the count wraps max -> 00:00.0
// -----------------------------------------------------------------------------
module stopwatch_2hz_ctrl #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [3:0] MAX_MIN_TENS = 4'd5,
    parameter logic [3:0] MAX_MIN_ONES = 4'd9
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       clk_2hz,
    input  logic       start_stop,
    input  logic       clear,
    output logic       tick_out,
    output logic       half,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync_2hz;
    logic [SYNC_STAGES-1:0] r_sync_ss;
    logic [SYNC_STAGES-1:0] r_sync_clr;
    logic                   r_prev_2hz;
    logic                   r_prev_ss;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_2hz <= '0;
            r_sync_ss  <= '0;
            r_sync_clr <= '0;
            r_prev_2hz <= 1'b0;
            r_prev_ss  <= 1'b0;
        end else begin
            r_sync_2hz <= {r_sync_2hz[SYNC_STAGES-2:0], clk_2hz};
            r_sync_ss  <= {r_sync_ss[SYNC_STAGES-2:0], start_stop};
            r_sync_clr <= {r_sync_clr[SYNC_STAGES-2:0], clear};
            r_prev_2hz <= r_sync_2hz[SYNC_STAGES-1];
            r_prev_ss  <= r_sync_ss[SYNC_STAGES-1];
        end
    end

    logic w_tick;
    logic w_ss_edge;
    logic w_clr;

    assign w_tick    = r_sync_2hz[SYNC_STAGES-1] & ~r_prev_2hz;
    assign w_ss_edge = r_sync_ss[SYNC_STAGES-1] & ~r_prev_ss;
    assign w_clr     = r_sync_clr[SYNC_STAGES-1];

    // tick_out is ungated: it reports every clk_2hz edge regardless of state
    // or clear, and rises on the same clk_50m edge that applies the count.
    logic r_tick_out;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_out <= 1'b0;
        end else begin
            r_tick_out <= w_tick;
        end
    end

    // ---------------------------------------------------------------------
    // Next-count computation (BCD ripple with wrap at the configured max)
    // ---------------------------------------------------------------------
    logic       r_half;
    logic [3:0] r_sec_ones;
    logic [3:0] r_sec_tens;
    logic [3:0] r_min_ones;
    logic [3:0] r_min_tens;

    logic       w_half_next;
    logic [3:0] w_sec_ones_next;
    logic [3:0] w_sec_tens_next;
    logic [3:0] w_min_ones_next;
    logic [3:0] w_min_tens_next;
    logic       w_at_max;

    assign w_at_max = r_half
                    && (r_sec_ones == 4'd9)
                    && (r_sec_tens == 4'd5)
                    && (r_min_ones == MAX_MIN_ONES)
                    && (r_min_tens == MAX_MIN_TENS);

    always_comb begin
        w_half_next     = ~r_half;
        w_sec_ones_next = r_sec_ones;
        w_sec_tens_next = r_sec_tens;
        w_min_ones_next = r_min_ones;
        w_min_tens_next = r_min_tens;
        if (w_at_max) begin
            w_half_next     = 1'b0;
            w_sec_ones_next = 4'd0;
            w_sec_tens_next = 4'd0;
            w_min_ones_next = 4'd0;
            w_min_tens_next = 4'd0;
        end else if (r_half) begin
            // .5 -> .0 carries into the seconds
            if (r_sec_ones == 4'd9) begin
                w_sec_ones_next = 4'd0;
                if (r_sec_tens == 4'd5) begin
                    w_sec_tens_next = 4'd0;
                    if (r_min_ones == 4'd9) begin
                        w_min_ones_next = 4'd0;
                        w_min_tens_next = r_min_tens + 4'd1;
                    end else begin
                        w_min_ones_next = r_min_ones + 4'd1;
                    end
                end else begin
                    w_sec_tens_next = r_sec_tens + 4'd1;
                end
            end else begin
                w_sec_ones_next = r_sec_ones + 4'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered running/rollover and the digit registers
    // ---------------------------------------------------------------------
    state_t r_state;
    logic   r_running;
    logic   r_rollover;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_rollover <= 1'b0;
            r_half     <= 1'b0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
        end else begin
            r_rollover <= 1'b0;
            if (w_clr) begin
                // Clear dominates ticks and key edges for as long as it is held.
                r_state    <= ST_IDLE;
                r_running  <= 1'b0;
                r_half     <= 1'b0;
                r_sec_ones <= 4'd0;
                r_sec_tens <= 4'd0;
                r_min_ones <= 4'd0;
                r_min_tens <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_edge) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // A coincident tick is still counted before pausing.
                        if (w_tick) begin
                            r_half     <= w_half_next;
                            r_sec_ones <= w_sec_ones_next;
                            r_sec_tens <= w_sec_tens_next;
                            r_min_ones <= w_min_ones_next;
                            r_min_tens <= w_min_tens_next;
                            r_rollover <= w_at_max;
                        end
                        if (w_ss_edge) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        // A tick arriving with the resume edge is not counted.
                        if (w_ss_edge) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick_out = r_tick_out;
    assign half     = r_half;
    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign running  = r_running;
    assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_2hz_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_2hz_ctrl
//
// Scoreboard bench: stimulus tasks update a behavioural model (count held as a
// plain number of half-seconds) and push the expected readout for every
// clk_2hz rising edge; a separate monitor pops one entry per tick_out pulse.
// -----------------------------------------------------------------------------
module tb_stopwatch_2hz_ctrl;

    localparam int MAX_HS = 60 * 60 * 2;   // half-seconds in 60 minutes

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       clk_2hz;
    logic       start_stop;
    logic       clear;
    logic       tick_out;
    logic       half;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;

    stopwatch_2hz_ctrl #(
        .SYNC_STAGES  (2),
        .MAX_MIN_TENS (4'd5),
        .MAX_MIN_ONES (4'd9)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .clk_2hz    (clk_2hz),
        .start_stop (start_stop),
        .clear      (clear),
        .tick_out   (tick_out),
        .half       (half),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .rollover   (rollover)
    );

    always #10 clk_50m = ~clk_50m;

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int hs;
        bit run;
        bit roll;
    } exp_t;

    exp_t exp_q[$];

    // model state: m_st 0 = idle, 1 = run, 2 = pause
    int m_hs = 0;
    int m_st = 0;
    bit m_roll = 1'b0;

    bit allow_spurious = 1'b0;
    int spurious = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [16:0] pack_hs(input int hs);
        int secs;
        int s;
        int m;
        secs = hs / 2;
        s = secs % 60;
        m = secs / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 1'(hs % 2)};
    endfunction

    function automatic logic [16:0] dut_pack();
        return {min_tens, min_ones, sec_tens, sec_ones, half};
    endfunction

    // One input event as seen after synchronisation: t = clk_2hz edge,
    // e = start_stop edge, c = clear level.
    task automatic model_event(input bit t, input bit e, input bit c);
        exp_t x;
        m_roll = 1'b0;
        if (c) begin
            m_st = 0;
            m_hs = 0;
        end else begin
            if (m_st == 1 && t) begin
                m_hs++;
                if (m_hs == MAX_HS) begin
                    m_hs = 0;
                    m_roll = 1'b1;
                end
            end
            if (e) m_st = (m_st == 1) ? 2 : 1;
        end
        if (t) begin
            x.hs = m_hs;
            x.run = (m_st == 1);
            x.roll = m_roll;
            exp_q.push_back(x);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   prev_tick = 1'b0;

    always @(negedge clk_50m) begin
        if (rst_n) begin
            if (tick_out) begin
                chk("tick_width", 32'(prev_tick), 32'd0);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tick_digits", 32'(dut_pack()), 32'(pack_hs(mon_e.hs)));
                    chk("tick_running", 32'(running), 32'(mon_e.run));
                    chk("tick_rollover", 32'(rollover), 32'(mon_e.roll));
                end else if (allow_spurious) begin
                    spurious++;
                    chk("spurious_digits", 32'(dut_pack()), 32'd0);
                    chk("spurious_running", 32'(running), 32'd0);
                end else begin
                    n_checks++;
                    $display("FAIL unexpected_tick: got tick_out=1 required no pulse at %0t", $time);
                end
            end else begin
                chk("rollover_idle", 32'(rollover), 32'd0);
            end
            prev_tick = tick_out;
        end else begin
            prev_tick = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic check_now(input string name);
        chk({name, "_digits"}, 32'(dut_pack()), 32'(pack_hs(m_hs)));
        chk({name, "_running"}, 32'(running), 32'(m_st == 1));
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic drive_tick(input int hi, input int lo, input bit with_ss, input bit chk_lat);
        int lat;
        lat = -1;
        clk_2hz = 1'b1;
        if (with_ss) start_stop = 1'b1;
        model_event(1'b1, with_ss, clear);
        for (int c = 1; c <= hi; c++) begin
            @(posedge clk_50m);
            #1;
            if (tick_out && lat < 0) lat = c;
        end
        clk_2hz = 1'b0;
        start_stop = 1'b0;
        if (chk_lat) begin
            n_checks++;
            if (lat >= 3 && lat <= 4) n_pass++;
            else $display("FAIL tick_latency: got %0d cycles required 3..4", lat);
        end
        wait_cyc(lo);
    endtask

    task automatic ss_pulse();
        start_stop = 1'b1;
        model_event(1'b0, 1'b1, clear);
        wait_cyc(4);
        start_stop = 1'b0;
        wait_cyc(4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int op;
        rst_n = 1'b0;
        clk_2hz = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        wait_cyc(3);
        chk("reset_digits", 32'(dut_pack()), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_tick_rollover", {30'd0, tick_out, rollover}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // 1: start then four slow ticks -> 00:02.0
        ss_pulse();
        for (int i = 0; i < 4; i++) drive_tick(20, 20, 1'b0, 1'b1);
        chk("t1_digits", 32'(dut_pack()), 32'({4'd0, 4'd0, 4'd0, 4'd2, 1'b0}));
        chk("t1_running", 32'(running), 32'd1);

        // 2: up to 00:59.5, then one more -> 01:00.0
        while (m_hs < 119) drive_tick(3, 3, 1'b0, 1'b0);
        chk("t2_pre", 32'(dut_pack()), 32'({4'd0, 4'd0, 4'd5, 4'd9, 1'b1}));
        drive_tick(20, 20, 1'b0, 1'b1);
        chk("t2_carry", 32'(dut_pack()), 32'({4'd0, 4'd1, 4'd0, 4'd0, 1'b0}));

        // 3: up to 59:59.5, then wrap
        while (m_hs < MAX_HS - 1) drive_tick(3, 3, 1'b0, 1'b0);
        chk("t3_pre", 32'(dut_pack()), 32'({4'd5, 4'd9, 4'd5, 4'd9, 1'b1}));
        drive_tick(20, 20, 1'b0, 1'b1);
        chk("t3_wrap", 32'(dut_pack()), 32'd0);
        chk("t3_running", 32'(running), 32'd1);

        // 4: coincident edge + tick in RUN, ignored ticks in PAUSE, resume
        drive_tick(20, 20, 1'b1, 1'b0);
        chk("t4_counted", 32'(dut_pack()), 32'({4'd0, 4'd0, 4'd0, 4'd0, 1'b1}));
        chk("t4_paused", 32'(running), 32'd0);
        drive_tick(20, 20, 1'b0, 1'b0);
        drive_tick(20, 20, 1'b0, 1'b0);
        drive_tick(20, 20, 1'b1, 1'b0);
        chk("t4_resume_uncounted", 32'(dut_pack()), 32'({4'd0, 4'd0, 4'd0, 4'd0, 1'b1}));
        drive_tick(20, 20, 1'b0, 1'b0);
        check_now("t4_end");

        // randomized mix
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                drive_tick(int'($urandom_range(3, 20)), int'($urandom_range(3, 20)), 1'b0, 1'b0);
            end else if (op == 6) begin
                drive_tick(int'($urandom_range(3, 20)), int'($urandom_range(3, 20)), 1'b1, 1'b0);
            end else if (op <= 8) begin
                ss_pulse();
            end else begin
                clear = 1'b1;
                model_event(1'b0, 1'b0, 1'b1);
                wait_cyc(2);
                drive_tick(3, 3, 1'($urandom_range(0, 1)), 1'b0);
                clear = 1'b0;
                wait_cyc(4);
            end
        end
        check_now("rand_end");

        // 5: clear mid-RUN with a tick and a key edge arriving
        if (m_st != 1) ss_pulse();
        drive_tick(20, 20, 1'b0, 1'b0);
        drive_tick(20, 20, 1'b0, 1'b0);
        clear = 1'b1;
        model_event(1'b0, 1'b0, 1'b1);
        drive_tick(3, 3, 1'b1, 1'b0);
        wait_cyc(4);
        clear = 1'b0;
        wait_cyc(4);
        chk("t5_digits", 32'(dut_pack()), 32'd0);
        chk("t5_running", 32'(running), 32'd0);
        drive_tick(20, 20, 1'b0, 1'b0);
        check_now("t5_idle_tick");

        // 6: async reset mid-count, with a tick in flight
        ss_pulse();
        drive_tick(20, 20, 1'b0, 1'b0);
        drive_tick(20, 20, 1'b0, 1'b0);
        clk_2hz = 1'b1;
        @(posedge clk_50m);
        @(posedge clk_50m);
        #5;
        rst_n = 1'b0;
        #1;
        chk("t6_async_digits", 32'(dut_pack()), 32'd0);
        chk("t6_async_flags", {29'd0, running, tick_out, rollover}, 32'd0);
        exp_q.delete();
        m_hs = 0;
        m_st = 0;
        @(posedge clk_50m);
        @(posedge clk_50m);
        @(posedge clk_50m);
        #5;
        allow_spurious = 1'b1;
        rst_n = 1'b1;
        wait_cyc(10);
        chk("t6_spurious_le1", 32'(spurious <= 1), 32'd1);
        check_now("t6_after");
        clk_2hz = 1'b0;
        wait_cyc(6);
        allow_spurious = 1'b0;
        drive_tick(20, 20, 1'b0, 1'b0);
        check_now("t6_idle");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
